// File: rtl/ship_motion_ctrl.sv
// Frame-synchronous ship x-position controller: synchronised, debounced buttons
// drive a left/right motion FSM with a per-frame speed ramp and wall clamping.
//
// state  | meaning
// IDLE   | no motion, ship_x held
// MOVE_L | moving left, ship_x decreases by speed each frame
// MOVE_R | moving right, ship_x increases by speed each frame
module ship_motion_ctrl #(
  parameter int CORDW       = 16,
  parameter int X_MAX       = 512,
  parameter int X_INIT      = 256,
  parameter int DB_CYCLES   = 250000,
  parameter int SPEED_MIN   = 1,
  parameter int SPEED_MAX   = 8,
  parameter int RAMP_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame,
  input  logic             btn_right_n,
  input  logic             btn_left_n,
  input  logic             recenter,
  output logic [CORDW-1:0] ship_x,
  output logic             moving,
  output logic             dir,
  output logic             at_left,
  output logic             at_right
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int SPW = $clog2(SPEED_MAX + 1);
  localparam int RW  = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam int XW  = CORDW + 1;

  typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R} state_t;

  // Synchronisers hold raw polarity; reset to the released level.
  logic [1:0] sync_r, sync_l, sync_c;
  logic [2:0] in_sync;
  logic [2:0] db_val;
  logic [DBW-1:0] db_cnt [3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
      sync_l <= 2'b11;
      sync_c <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_right_n};
      sync_l <= {sync_l[0], btn_left_n};
      sync_c <= {sync_c[0], recenter};
    end
  end

  assign in_sync = {sync_c[1], ~sync_l[1], ~sync_r[1]};

  for (genvar i = 0; i < 3; i++) begin : g_db
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        db_cnt[i] <= '0;
        db_val[i] <= 1'b0;
      end else if (in_sync[i] != db_val[i]) begin
        if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          db_val[i] <= in_sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end else begin
        db_cnt[i] <= '0;
      end
    end
  end

  logic db_r, db_l, db_c;
  assign db_r = db_val[0];
  assign db_l = db_val[1];
  assign db_c = db_val[2];

  state_t           state, state_n, want;
  logic [SPW-1:0]   speed, speed_n;
  logic [RW-1:0]    ramp, ramp_n;
  logic [CORDW-1:0] x_n;
  logic             dir_n;
  logic [XW-1:0]    sum_r;

  assign sum_r = {1'b0, ship_x} + XW'(speed);

  always_comb begin
    state_n = state;
    speed_n = speed;
    ramp_n  = ramp;
    x_n     = ship_x;
    dir_n   = dir;
    want    = IDLE;
    if (frame) begin
      if (db_c) begin
        state_n = IDLE;
        x_n     = CORDW'(X_INIT);
        speed_n = SPW'(SPEED_MIN);
        ramp_n  = '0;
      end else begin
        // Position moves with the state and speed in force before this frame.
        case (state)
          MOVE_R: x_n = (sum_r > XW'(X_MAX)) ? CORDW'(X_MAX) : sum_r[CORDW-1:0];
          MOVE_L: x_n = (ship_x < CORDW'(speed)) ? '0 : ship_x - CORDW'(speed);
          default: x_n = ship_x;
        endcase
        if (db_r && !db_l)      want = MOVE_R;
        else if (db_l && !db_r) want = MOVE_L;
        else                    want = IDLE;
        state_n = want;
        if (want != IDLE) begin
          dir_n = (want == MOVE_R);
          if (want == state) begin
            if (ramp == RW'(RAMP_FRAMES - 1)) begin
              ramp_n = '0;
              if (speed < SPW'(SPEED_MAX)) speed_n = speed + 1'b1;
            end else begin
              ramp_n = ramp + 1'b1;
            end
          end else begin
            speed_n = SPW'(SPEED_MIN);
            ramp_n  = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      speed    <= SPW'(SPEED_MIN);
      ramp     <= '0;
      ship_x   <= CORDW'(X_INIT);
      dir      <= 1'b0;
      at_left  <= (X_INIT == 0);
      at_right <= (X_INIT == X_MAX);
    end else begin
      state    <= state_n;
      speed    <= speed_n;
      ramp     <= ramp_n;
      ship_x   <= x_n;
      dir      <= dir_n;
      at_left  <= (x_n == '0);
      at_right <= (x_n == CORDW'(X_MAX));
    end
  end

  assign moving = (state != IDLE);

endmodule

// File: tb/tb_ship_motion_ctrl.sv
// Bench for ship_motion_ctrl: directed steps plus randomized button traffic,
// checked frame by frame against a behavioural position/speed model.
module tb_ship_motion_ctrl;

  localparam int XMAX = 20;
  localparam int XINI = 10;
  localparam int RF   = 2;
  localparam int SMIN = 1;
  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst_n, frame, btn_right_n, btn_left_n, recenter;
  logic [15:0] ship_x;
  logic        moving, dir, at_left, at_right;

  int total = 0;
  int bad   = 0;

  // model: intended (settled) input levels and ship behaviour
  bit r_p, l_p, c_p;
  int m_x, m_mode, m_hold, m_dir;   // m_mode: 0 none, -1 left, +1 right

  ship_motion_ctrl #(
    .CORDW(16), .X_MAX(XMAX), .X_INIT(XINI), .DB_CYCLES(4),
    .SPEED_MIN(SMIN), .SPEED_MAX(SMAX), .RAMP_FRAMES(RF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .btn_right_n(btn_right_n),
    .btn_left_n(btn_left_n), .recenter(recenter), .ship_x(ship_x),
    .moving(moving), .dir(dir), .at_left(at_left), .at_right(at_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ship_x"}, 32'(ship_x), 32'(m_x));
    check({tag, ".moving"}, 32'(moving), 32'(m_mode != 0));
    check({tag, ".dir"}, 32'(dir), 32'(m_dir));
    check({tag, ".at_left"}, 32'(at_left), 32'(m_x == 0));
    check({tag, ".at_right"}, 32'(at_right), 32'(m_x == XMAX));
  endtask

  task automatic model_reset();
    m_x = XINI; m_mode = 0; m_hold = 0; m_dir = 0;
  endtask

  // Speed grows by one every RF frames of continued motion, saturating.
  task automatic model_frame();
    int want, spd;
    if (c_p) begin
      m_x = XINI; m_mode = 0; m_hold = 0;
    end else begin
      want = (r_p && !l_p) ? 1 : (l_p && !r_p) ? -1 : 0;
      spd  = SMIN + m_hold / RF;
      if (spd > SMAX) spd = SMAX;
      if (m_mode != 0) begin
        m_x = m_x + m_mode * spd;
        if (m_x < 0) m_x = 0;
        if (m_x > XMAX) m_x = XMAX;
      end
      if (want != 0) begin
        m_hold = (want == m_mode) ? m_hold + 1 : 0;
        m_dir  = (want == 1);
      end
      m_mode = want;
    end
  endtask

  task automatic set_btns(input bit r, input bit l, input bit c);
    r_p = r; l_p = l; c_p = c;
    btn_right_n = ~r; btn_left_n = ~l; recenter = c;
  endtask

  task automatic pulse_frame(input string tag);
    @(negedge clk) frame = 1'b1;
    @(negedge clk) frame = 1'b0;
    model_frame();
    check_all(tag);
  endtask

  task automatic do_frame(input string tag);
    repeat (40) @(negedge clk);
    pulse_frame(tag);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int seq[8];
    int xp, len, which;
    seq = '{10, 11, 12, 14, 16, 19, 20, 20};
    rst_n = 1'b0; frame = 1'b0;
    set_btns(0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // 3-cycle glitch on right button must be ignored
    @(negedge clk) btn_right_n = 1'b0;
    repeat (3) @(negedge clk);
    btn_right_n = 1'b1;
    repeat (3) do_frame("glitch");

    // held right: frame 7 cycles after press sees the debounced level
    set_btns(1, 0, 0);
    repeat (5) @(negedge clk);
    pulse_frame("db_latency");
    check("ramp_seq0", 32'(ship_x), 32'(seq[0]));
    repeat (8) @(negedge clk);
    for (int k = 1; k < 8; k++) begin
      do_frame("ramp");
      check($sformatf("ramp_seq%0d", k), 32'(ship_x), 32'(seq[k]));
    end
    check("wall_right", 32'(at_right), 32'd1);

    // reverse to left and run into the floor
    set_btns(0, 1, 0);
    for (int k = 0; k < 12; k++) do_frame("left");
    check("floor_x", 32'(ship_x), 32'd0);
    check("floor_at_left", 32'(at_left), 32'd1);

    // both pressed: idle, position held
    set_btns(1, 1, 0);
    repeat (2) do_frame("both");
    check("both_moving", 32'(moving), 32'd0);

    // right for a few frames, then reversal restarts speed at 1
    set_btns(1, 0, 0);
    repeat (6) do_frame("pre_rev");
    set_btns(0, 1, 0);
    do_frame("rev_entry");
    check("rev_dir", 32'(dir), 32'd0);
    xp = int'(ship_x);
    do_frame("rev_step");
    check("rev_speed1", 32'(ship_x), 32'(xp - 1));

    // recenter while moving right: nothing changes until the frame pulse
    set_btns(1, 0, 0);
    repeat (3) do_frame("pre_rc");
    set_btns(1, 0, 1);
    repeat (20) @(negedge clk);
    check_all("rc_before_frame");
    do_frame("rc_frame");
    check("rc_x", 32'(ship_x), 32'(XINI));
    set_btns(1, 0, 0);
    repeat (3) do_frame("post_rc");

    // reset coinciding with a frame pulse mid-motion
    @(negedge clk) begin rst_n = 1'b0; frame = 1'b1; end
    @(negedge clk) begin rst_n = 1'b1; frame = 1'b0; end
    model_reset();
    check_all("mid_reset");
    set_btns(0, 0, 0);
    do_frame("post_reset");

    // randomized traffic with sub-window glitches
    for (int k = 0; k < 40; k++) begin
      set_btns(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0));
      repeat (12) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        len   = $urandom_range(1, 3);
        which = $urandom_range(0, 2);
        if (which == 0) btn_right_n = ~btn_right_n;
        else if (which == 1) btn_left_n = ~btn_left_n;
        else recenter = ~recenter;
        repeat (len) @(negedge clk);
        btn_right_n = ~r_p; btn_left_n = ~l_p; recenter = c_p;
      end
      do_frame("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
